// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared definitions for the pipeline flow controller: FSM encodings,
// branch-history counter type and its saturating update helper.
package pipe_flow_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } fsm_state_e;

  typedef logic [1:0] bht_ctr_t;

  // Weakly not-taken: one taken outcome flips the prediction.
  localparam bht_ctr_t BHT_INIT = 2'b01;

  // Fall-through distance for a 32-bit instruction.
  localparam int unsigned PC_INC = 4;

  // Two-bit saturating counter step: up on taken, down on not-taken.
  function automatic bht_ctr_t bht_sat_update(input bht_ctr_t ctr, input logic taken);
    bht_ctr_t res;
    if (taken) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_flow_ctrl_if.sv
// Bundle of pipeline-status inputs and stall/flush/redirect outputs
// exchanged between the core datapath (master) and the flow controller (slave).
interface pipe_flow_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [XLEN-1:0]  id_pc;
  logic             id_is_branch;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_valid;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_is_branch;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_pred_taken;
  logic             ex_br_taken;
  logic [XLEN-1:0]  ex_target;
  logic             trap_req;
  logic [XLEN-1:0]  trap_vec;
  logic             pred_taken;
  logic             stall_if;
  logic             flush_if;
  logic             flush_id;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             busy;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output id_valid, id_pc, id_is_branch, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    output ex_valid, ex_rd, ex_is_load, ex_is_branch, ex_pc, ex_pred_taken,
    output ex_br_taken, ex_target, trap_req, trap_vec,
    input  pred_taken, stall_if, flush_if, flush_id, redirect_valid, redirect_pc,
    input  busy, mispredict_cnt
  );

  modport slave (
    input  id_valid, id_pc, id_is_branch, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
    input  ex_valid, ex_rd, ex_is_load, ex_is_branch, ex_pc, ex_pred_taken,
    input  ex_br_taken, ex_target, trap_req, trap_vec,
    output pred_taken, stall_if, flush_if, flush_id, redirect_valid, redirect_pc,
    output busy, mispredict_cnt
  );
endinterface

// File: rtl/pipe_flow_ctrl_bht_2bit.sv
// Branch history table of 2-bit saturating counters. Combinational read,
// registered update; a same-index read during an update sees the old value.
module bht_2bit
  import pipe_flow_ctrl_pkg::*;
#(
  parameter int BHT_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BHT_IDX_W-1:0] i_rd_idx,
  output bht_ctr_t             o_rd_ctr,
  input  logic                 i_upd_en,
  input  logic [BHT_IDX_W-1:0] i_upd_idx,
  input  logic                 i_upd_taken
);
  localparam int N_ENTRIES = 1 << BHT_IDX_W;

  bht_ctr_t r_tbl [N_ENTRIES];

  assign o_rd_ctr = r_tbl[i_rd_idx];

  // Initialise every counter on reset, otherwise apply the resolved outcome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        r_tbl[i] <= BHT_INIT;
      end
    end else if (i_upd_en) begin
      r_tbl[i_upd_idx] <= bht_sat_update(r_tbl[i_upd_idx], i_upd_taken);
    end
  end

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline sequencer: arbitrates mispredict recovery, trap drain/redirect
// and load-use stalls into one set of stall/flush/redirect controls.
module pipe_flow_ctrl
  import pipe_flow_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int BHT_IDX_W    = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic              clk,
  input logic              rst_n,
  pipe_flow_ctrl_if.slave  bus
);
  localparam int DCNT_W = $clog2(DRAIN_CYCLES + 1);

  fsm_state_e        r_state;
  logic [XLEN-1:0]   r_trap_vec;
  logic [DCNT_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0]  r_mp_cnt;
  logic              r_busy;
  logic              r_drain_hold;
  logic              r_redir;

  bht_ctr_t          w_bht_ctr;
  logic              w_idle;
  logic              w_mispredict;
  logic              w_trap_acc;
  logic              w_load_use;
  logic              w_src_hit;
  logic [XLEN-1:0]   w_mp_pc;
  logic              w_pred_taken;
  logic              w_stall_if;
  logic              w_flush_if;
  logic              w_flush_id;
  logic              w_redirect_valid;
  logic [XLEN-1:0]   w_redirect_pc;
  logic              w_unused_pc;

  // Only the word-index bits of the ID PC select a BHT entry.
  assign w_unused_pc = ^{bus.id_pc[XLEN-1:BHT_IDX_W+2], bus.id_pc[1:0]};

  bht_2bit #(
    .BHT_IDX_W (BHT_IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rd_idx    (bus.id_pc[BHT_IDX_W+1:2]),
    .o_rd_ctr    (w_bht_ctr),
    .i_upd_en    (bus.ex_valid & bus.ex_is_branch),
    .i_upd_idx   (bus.ex_pc[BHT_IDX_W+1:2]),
    .i_upd_taken (bus.ex_br_taken)
  );

  // Event detection; the trap sequence masks everything, and priority is
  // mispredict > trap acceptance > load-use.
  always_comb begin
    w_idle       = (r_state == ST_IDLE);
    w_mispredict = w_idle & bus.ex_valid & bus.ex_is_branch &
                   (bus.ex_br_taken != bus.ex_pred_taken);
    w_trap_acc   = w_idle & ~w_mispredict & bus.trap_req & bus.id_valid;
    w_src_hit    = (bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                   (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd));
    w_load_use   = w_idle & ~w_mispredict & ~w_trap_acc & bus.id_valid &
                   bus.ex_valid & bus.ex_is_load & (bus.ex_rd != 5'd0) & w_src_hit;
    w_mp_pc      = bus.ex_br_taken ? bus.ex_target : (bus.ex_pc + XLEN'(PC_INC));
  end

  // Merge event controls with the FSM's registered controls; reset forces 0.
  always_comb begin
    w_pred_taken     = 1'b0;
    w_stall_if       = 1'b0;
    w_flush_if       = 1'b0;
    w_flush_id       = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = {XLEN{1'b0}};
    if (!rst_n) begin
      w_pred_taken     = 1'b0;
      w_redirect_valid = 1'b0;
    end else begin
      w_pred_taken     = bus.id_valid & bus.id_is_branch & w_bht_ctr[1];
      w_stall_if       = w_load_use | r_drain_hold;
      w_flush_if       = w_mispredict | w_trap_acc | r_redir;
      w_flush_id       = w_mispredict | w_trap_acc | w_load_use | r_drain_hold;
      w_redirect_valid = w_mispredict | r_redir;
      if (w_mispredict) begin
        w_redirect_pc = w_mp_pc;
      end else if (r_redir) begin
        w_redirect_pc = r_trap_vec;
      end else begin
        w_redirect_pc = {XLEN{1'b0}};
      end
    end
  end

  // Trap sequencer: IDLE -> DRAIN (DRAIN_CYCLES) -> REDIRECT -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_trap_vec   <= {XLEN{1'b0}};
      r_drain_cnt  <= {DCNT_W{1'b0}};
      r_busy       <= 1'b0;
      r_drain_hold <= 1'b0;
      r_redir      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_trap_acc) begin
            r_state      <= ST_DRAIN;
            r_trap_vec   <= bus.trap_vec;
            r_drain_cnt  <= DCNT_W'(DRAIN_CYCLES);
            r_busy       <= 1'b1;
            r_drain_hold <= 1'b1;
            r_redir      <= 1'b0;
          end else begin
            r_busy       <= 1'b0;
            r_drain_hold <= 1'b0;
            r_redir      <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == DCNT_W'(1)) begin
            r_state      <= ST_REDIRECT;
            r_drain_cnt  <= {DCNT_W{1'b0}};
            r_drain_hold <= 1'b0;
            r_redir      <= 1'b1;
          end else begin
            r_drain_cnt  <= r_drain_cnt - DCNT_W'(1);
          end
        end
        ST_REDIRECT: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_drain_hold <= 1'b0;
          r_redir      <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_drain_hold <= 1'b0;
          r_redir      <= 1'b0;
        end
      endcase
    end
  end

  // Count every accepted mispredict; wraps naturally at 2**CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mp_cnt <= {CNT_W{1'b0}};
    end else if (w_mispredict) begin
      r_mp_cnt <= r_mp_cnt + CNT_W'(1);
    end
  end

  assign bus.pred_taken     = w_pred_taken;
  assign bus.stall_if       = w_stall_if;
  assign bus.flush_if       = w_flush_if;
  assign bus.flush_id       = w_flush_id;
  assign bus.redirect_valid = w_redirect_valid;
  assign bus.redirect_pc    = w_redirect_pc;
  assign bus.busy           = r_busy;
  assign bus.mispredict_cnt = r_mp_cnt;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl: BHT training/saturation, load-use,
// mispredict recovery and priority, trap sequence and mid-sequence reset.
module tb_pipe_flow_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipe_flow_ctrl_if #(.XLEN(32), .CNT_W(16)) bus ();

  pipe_flow_ctrl #(
    .XLEN(32), .BHT_IDX_W(4), .DRAIN_CYCLES(2), .CNT_W(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.id_valid = 1'b0; bus.id_pc = 32'h0; bus.id_is_branch = 1'b0;
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_rd = 5'd0; bus.ex_is_load = 1'b0; bus.ex_is_branch = 1'b0;
    bus.ex_pc = 32'h0; bus.ex_pred_taken = 1'b0; bus.ex_br_taken = 1'b0; bus.ex_target = 32'h0;
    bus.trap_req = 1'b0; bus.trap_vec = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pred"},   {31'd0, bus.pred_taken},     32'd0);
    chk({tag, "_stall"},  {31'd0, bus.stall_if},       32'd0);
    chk({tag, "_fif"},    {31'd0, bus.flush_if},       32'd0);
    chk({tag, "_fid"},    {31'd0, bus.flush_id},       32'd0);
    chk({tag, "_rv"},     {31'd0, bus.redirect_valid}, 32'd0);
    chk({tag, "_rpc"},    bus.redirect_pc,             32'd0);
    chk({tag, "_busy"},   {31'd0, bus.busy},           32'd0);
    chk({tag, "_mpcnt"},  {16'd0, bus.mispredict_cnt}, 32'd0);
  endtask

  // Correctly predicted branch resolving in EX (no mispredict), one edge.
  task automatic bht_upd(input logic [31:0] pc, input logic tk);
    bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_pc = pc;
    bus.ex_br_taken = tk; bus.ex_pred_taken = tk;
    step();
    bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    bus.id_valid = 1'b1; bus.id_is_branch = 1'b1; bus.id_pc = 32'h40;
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // BHT: index 0 starts weakly not-taken.
    chk("bht_init_pred", {31'd0, bus.pred_taken}, 32'd0);
    bus.id_pc = 32'h44;
    #1 chk("bht_init_pred_idx1", {31'd0, bus.pred_taken}, 32'd0);
    bus.id_pc = 32'h40;
    // Update in flight to the same index: read still sees old 01.
    bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_pc = 32'h40;
    bus.ex_br_taken = 1'b1; bus.ex_pred_taken = 1'b1;
    #1 chk("bht_no_bypass", {31'd0, bus.pred_taken}, 32'd0);
    step();
    bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0;
    #1 chk("bht_after_t1", {31'd0, bus.pred_taken}, 32'd1);   // 10
    bht_upd(32'h40, 1'b1);                                    // 11
    chk("bht_after_t2", {31'd0, bus.pred_taken}, 32'd1);
    bht_upd(32'h40, 1'b1);
    bht_upd(32'h40, 1'b1);                                    // stays 11
    chk("bht_sat_hi", {31'd0, bus.pred_taken}, 32'd1);
    bht_upd(32'h40, 1'b0);                                    // 10
    chk("bht_dec1", {31'd0, bus.pred_taken}, 32'd1);
    bht_upd(32'h40, 1'b0);                                    // 01
    chk("bht_dec2", {31'd0, bus.pred_taken}, 32'd0);
    bht_upd(32'h40, 1'b0);                                    // 00
    bht_upd(32'h40, 1'b0);                                    // stays 00
    bht_upd(32'h40, 1'b1);                                    // 01
    chk("bht_sat_lo", {31'd0, bus.pred_taken}, 32'd0);
    bht_upd(32'h40, 1'b1);                                    // 10
    chk("bht_sat_lo_inc", {31'd0, bus.pred_taken}, 32'd1);
    bus.id_pc = 32'h44;
    #1 chk("bht_idx1_untouched", {31'd0, bus.pred_taken}, 32'd0);
    chk("bht_no_mp_cnt", {16'd0, bus.mispredict_cnt}, 32'd0);

    // Load-use via rs1.
    idle_inputs();
    bus.id_valid = 1'b1; bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
    bus.ex_valid = 1'b1; bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5;
    #1;
    chk("lu_stall", {31'd0, bus.stall_if}, 32'd1);
    chk("lu_fid", {31'd0, bus.flush_id}, 32'd1);
    chk("lu_fif", {31'd0, bus.flush_if}, 32'd0);
    chk("lu_rv", {31'd0, bus.redirect_valid}, 32'd0);
    bus.id_rs1 = 5'd0; bus.ex_rd = 5'd0;
    #1;
    chk("lu_x0_stall", {31'd0, bus.stall_if}, 32'd0);
    chk("lu_x0_fid", {31'd0, bus.flush_id}, 32'd0);
    // Load-use via rs2, then rs2 not read.
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b1; bus.id_rs2 = 5'd7; bus.ex_rd = 5'd7;
    #1 chk("lu_rs2_stall", {31'd0, bus.stall_if}, 32'd1);
    bus.id_uses_rs2 = 1'b0;
    #1 chk("lu_rs2_unused", {31'd0, bus.stall_if}, 32'd0);

    // Mispredict not-taken at the top of the address space: PC+4 wraps.
    idle_inputs();
    bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_pc = 32'hFFFF_FFFC;
    bus.ex_pred_taken = 1'b1; bus.ex_br_taken = 1'b0; bus.ex_target = 32'h123;
    #1;
    chk("mpnt_rv", {31'd0, bus.redirect_valid}, 32'd1);
    chk("mpnt_rpc", bus.redirect_pc, 32'h0000_0000);
    chk("mpnt_fif", {31'd0, bus.flush_if}, 32'd1);
    chk("mpnt_fid", {31'd0, bus.flush_id}, 32'd1);
    chk("mpnt_cnt_before", {16'd0, bus.mispredict_cnt}, 32'd0);
    step();
    chk("mpnt_cnt_after", {16'd0, bus.mispredict_cnt}, 32'd1);

    // Mispredict taken with concurrent load-use and trap request.
    idle_inputs();
    bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_pc = 32'h84;
    bus.ex_pred_taken = 1'b0; bus.ex_br_taken = 1'b1; bus.ex_target = 32'h200;
    bus.ex_is_load = 1'b1; bus.ex_rd = 5'd5;
    bus.id_valid = 1'b1; bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1;
    bus.trap_req = 1'b1; bus.trap_vec = 32'h999;
    #1;
    chk("mpt_rpc", bus.redirect_pc, 32'h200);
    chk("mpt_rv", {31'd0, bus.redirect_valid}, 32'd1);
    chk("mpt_stall", {31'd0, bus.stall_if}, 32'd0);
    step();
    idle_inputs();
    #1;
    chk("mpt_busy", {31'd0, bus.busy}, 32'd0);
    chk("mpt_no_trap_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("mpt_cnt", {16'd0, bus.mispredict_cnt}, 32'd2);

    // Trap sequence.
    bus.id_valid = 1'b1; bus.trap_req = 1'b1; bus.trap_vec = 32'h1C0;
    #1;
    chk("trap_acc_fif", {31'd0, bus.flush_if}, 32'd1);
    chk("trap_acc_fid", {31'd0, bus.flush_id}, 32'd1);
    chk("trap_acc_busy", {31'd0, bus.busy}, 32'd0);
    chk("trap_acc_rv", {31'd0, bus.redirect_valid}, 32'd0);
    step();
    // DRAIN 1: a mispredict presented here must be ignored.
    idle_inputs();
    bus.trap_vec = 32'hDEAD;
    bus.ex_valid = 1'b1; bus.ex_is_branch = 1'b1; bus.ex_pc = 32'h108;
    bus.ex_pred_taken = 1'b1; bus.ex_br_taken = 1'b0;
    #1;
    chk("drain1_busy", {31'd0, bus.busy}, 32'd1);
    chk("drain1_stall", {31'd0, bus.stall_if}, 32'd1);
    chk("drain1_fid", {31'd0, bus.flush_id}, 32'd1);
    chk("drain1_fif", {31'd0, bus.flush_if}, 32'd0);
    chk("drain1_rv", {31'd0, bus.redirect_valid}, 32'd0);
    step();
    bus.ex_valid = 1'b0; bus.ex_is_branch = 1'b0;
    #1;
    chk("drain2_busy", {31'd0, bus.busy}, 32'd1);
    chk("drain2_stall", {31'd0, bus.stall_if}, 32'd1);
    chk("drain2_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("drain_cnt_held", {16'd0, bus.mispredict_cnt}, 32'd2);
    step();
    chk("redir_rv", {31'd0, bus.redirect_valid}, 32'd1);
    chk("redir_rpc", bus.redirect_pc, 32'h1C0);
    chk("redir_fif", {31'd0, bus.flush_if}, 32'd1);
    chk("redir_busy", {31'd0, bus.busy}, 32'd1);
    chk("redir_stall", {31'd0, bus.stall_if}, 32'd0);
    chk("redir_fid", {31'd0, bus.flush_id}, 32'd0);
    step();
    chk("post_busy", {31'd0, bus.busy}, 32'd0);
    chk("post_rv", {31'd0, bus.redirect_valid}, 32'd0);
    chk("post_fif", {31'd0, bus.flush_if}, 32'd0);

    // Reset in the middle of DRAIN.
    idle_inputs();
    bus.id_valid = 1'b1; bus.id_is_branch = 1'b1; bus.id_pc = 32'h40;
    #1 chk("pre_rst_pred", {31'd0, bus.pred_taken}, 32'd1);
    bus.trap_req = 1'b1; bus.trap_vec = 32'h2A0;
    step();
    bus.trap_req = 1'b0;
    #1 chk("rst_drain_busy", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    step();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_bht_reinit", {31'd0, bus.pred_taken}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_rv", {31'd0, bus.redirect_valid}, 32'd0);
      chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_flow_ctrl.md
Name: pipe_flow_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
- Generates every stall, flush and PC-redirect from three sources:
  - load-use hazard detection
  - a 2-bit saturating branch history table (BHT)
  - a trap drain sequence
- Replaces the ad-hoc stall/flush priority logic in the core top.
- Owns all IF/ID and ID/EX hold/clear decisions.

Parameters:
- XLEN, 32, datapath/PC width.
- BHT_IDX_W, 4, BHT index width; the table has 2**BHT_IDX_W entries.
- DRAIN_CYCLES, 2, cycles spent draining EX/MEM/WB before a trap redirect.
- CNT_W, 16, width of the mispredict counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  IF/ID holds a valid instruction
- id_pc  in  XLEN  PC of the instruction in ID
- id_is_branch  in  1  instruction in ID is a conditional branch
- id_rs1, id_rs2  in  5  source register addresses in ID
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction actually reads rs1 / rs2
- ex_valid  in  1  ID/EX holds a valid instruction
- ex_rd  in  5  destination register in EX
- ex_is_load  in  1  instruction in EX is a load
- ex_is_branch  in  1  instruction in EX is a conditional branch
- ex_pc  in  XLEN  PC of the instruction in EX
- ex_pred_taken  in  1  prediction carried down the pipe with this branch
- ex_br_taken  in  1  resolved branch outcome
- ex_target  in  XLEN  resolved taken target
- trap_req  in  1  ID-stage trap request (ECALL, EBREAK, misalign)
- trap_vec  in  XLEN  trap handler address
- pred_taken  out  1  prediction for the ID branch
- stall_if  out  1  hold PC and IF/ID
- flush_if  out  1  clear IF/ID to a bubble
- flush_id  out  1  load a bubble into ID/EX
- redirect_valid  out  1  load redirect_pc into the PC
- redirect_pc  out  XLEN  next fetch address
- busy  out  1  trap sequence in progress
- mispredict_cnt  out  CNT_W  count of mispredictions

Behaviour:
- Reset, asynchronous:
  - FSM enters IDLE.
  - Every BHT entry is set to 2'b01 (weakly not-taken).
  - mispredict_cnt, the latched trap vector and the drain counter are cleared to 0.
  - All outputs read 0.
- Prediction, combinational:
  - pred_taken = id_valid & id_is_branch & BHT[id_pc[BHT_IDX_W+1:2]][1].
- BHT update, registered:
  - Occurs on clk when ex_valid & ex_is_branch.
  - Entry index is ex_pc[BHT_IDX_W+1:2].
  - Taken outcome increments the entry, saturating at 11; not-taken decrements it, saturating at 00.
  - A read and write to the same index in one cycle returns the old value; there is no bypass.
- Mispredict, combinational:
  - Condition: ex_valid & ex_is_branch & (ex_br_taken != ex_pred_taken).
  - Asserts redirect_valid, flush_if and flush_id.
  - redirect_pc = ex_br_taken ? ex_target : ex_pc+4, with modulo 2**XLEN wrap.
  - mispredict_cnt increments on the same edge and wraps at 2**CNT_W.
- Load-use, combinational:
  - Condition: id_valid & ex_valid & ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Asserts stall_if and flush_id.
- Priority within a cycle: mispredict, then trap acceptance, then load-use.
  - Mispredict suppresses the load-use stall.
  - On a mispredict, trap_req is ignored because the trapping instruction is on the wrong path.
- FSM states: IDLE, DRAIN, REDIRECT.
  - IDLE to DRAIN: on trap_req & id_valid with no mispredict that cycle. Latch trap_vec, load the drain counter with DRAIN_CYCLES, assert flush_if and flush_id.
  - DRAIN: stall_if=1, flush_id=1, busy=1. Counter decrements each cycle; at 1 go to REDIRECT.
  - REDIRECT: redirect_valid=1, redirect_pc=latched vector, flush_if=1, busy=1. Go to IDLE next cycle.
  - In DRAIN and REDIRECT, trap_req, load-use and mispredict are ignored. EX holds only bubbles in these states.
- Reset mid-sequence returns the FSM to IDLE immediately. The latched vector is discarded.

Decomposition:
- Shared package (in GLOBALS):
  - FSM state encodings: IDLE=2'd0, DRAIN=2'd1, REDIRECT=2'd2.
  - BHT_INIT=2'b01.
  - PC increment constant 4.
- Sub-module bht_2bit:
  - Holds the counter array.
  - One combinational read port and one registered saturating-update port.
  - Parameterised by BHT_IDX_W.

Test Plan:
- Post-reset query: id_is_branch=1, id_pc=0x40 -> pred_taken=0. After two taken updates at ex_pc=0x40 -> pred_taken=1. After two more taken -> counter holds 11.
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> stall_if=1, flush_id=1, redirect_valid=0. Same stimulus with ex_rd=0 -> no stall.
- Mispredict not-taken: ex_pred_taken=1, ex_br_taken=0, ex_pc=0xFFFFFFFC -> redirect_pc=0x00000000, flush_if=flush_id=1, mispredict_cnt 0->1.
- Mispredict taken with concurrent load-use and trap_req: ex_target=0x200 -> redirect_pc=0x200, stall_if=0, FSM stays IDLE.
- Trap: trap_req=1, trap_vec=0x1C0 -> busy rises; 2 DRAIN cycles with stall_if=1; then 1 REDIRECT cycle with redirect_pc=0x1C0; then IDLE.
- rst_n pulsed low during DRAIN -> all outputs 0 and FSM IDLE asynchronously; no redirect after release.
